// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states,
// RV64 load/store funct3 encodings and access sizes.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RMW_READ,
    WRITE,
    RESP
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } lsu_size_e;

  function automatic lsu_size_e f3_size(
    input logic [2:0] f3
  );
    return lsu_size_e'(f3[1:0]);
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational sign/zero extension of the low 1/2/4/8 bytes.
// Ports: size_i, uns_i (1 = zero-extend), data_i -> data_o.
module lsu_extend
  import load_store_unit_pkg::*;
(
  input  lsu_size_e   size_i,
  input  logic        uns_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o
);

  logic sb_b;
  logic sb_h;
  logic sb_w;

  assign sb_b = ~uns_i & data_i[7];
  assign sb_h = ~uns_i & data_i[15];
  assign sb_w = ~uns_i & data_i[31];

  always_comb begin
    data_o = data_i;
    unique case (size_i)
      SZ_B: data_o = {{56{sb_b}}, data_i[7:0]};
      SZ_H: data_o = {{48{sb_h}}, data_i[15:0]};
      SZ_W: data_o = {{32{sb_w}}, data_i[31:0]};
      SZ_D: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: bounds-checked RV64 loads/stores
// with read-modify-write for sub-doubleword stores.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic [63:0] Mem_Addr,
  output logic [63:0] Write_Data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [63:0] Read_Data
);

  lsu_state_e  state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic        write_q, write_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] data_q, data_d;
  logic        rvalid_q, rvalid_d;
  logic [63:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;

  logic [64:0] end_addr;
  logic        oob;
  logic        bad_f3;
  logic [63:0] ld_ext;
  logic [63:0] st_mask;
  logic [63:0] merged;

  // 65-bit sum so addresses near 2^64 cannot wrap into range
  assign end_addr = {1'b0, req_addr} + 65'd8;
  assign oob      = end_addr > 65'(MEM_BYTES);
  assign bad_f3   = req_write ? req_funct3[2]
                              : (req_funct3 == 3'b111);

  lsu_extend u_ld_ext (
    .size_i (f3_size(f3_q)),
    .uns_i  (f3_q[2]),
    .data_i (Read_Data),
    .data_o (ld_ext)
  );

  // zero-extending all-ones yields the low-byte store mask
  lsu_extend u_st_mask (
    .size_i (f3_size(f3_q)),
    .uns_i  (1'b1),
    .data_i ({64{1'b1}}),
    .data_o (st_mask)
  );

  assign merged = (data_q & ~st_mask) | (wdata_q & st_mask);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    f3_d     = f3_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          f3_d    = req_funct3;
          write_d = req_write;
          wdata_d = req_wdata;
          if (oob || bad_f3) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rerr_d   = 1'b1;
          end else if (!req_write) begin
            state_d = READ;
          end else if (req_funct3 == SD) begin
            state_d = WRITE;
          end else begin
            state_d = RMW_READ;
          end
        end
      end
      READ: begin
        data_d   = Read_Data;
        state_d  = RESP;
        rvalid_d = 1'b1;
        rdata_d  = ld_ext;
        rerr_d   = 1'b0;
      end
      RMW_READ: begin
        data_d  = Read_Data;
        state_d = WRITE;
      end
      WRITE: begin
        state_d  = RESP;
        rvalid_d = 1'b1;
        rdata_d  = '0;
        rerr_d   = 1'b0;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      f3_q     <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      data_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      f3_q     <= f3_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign MemRead    = (state_q == READ) ||
                      (state_q == RMW_READ);
  assign MemWrite   = (state_q == WRITE) && write_q;
  assign Mem_Addr   = (MemRead || MemWrite) ? addr_q : '0;
  assign Write_Data = MemWrite ? merged : '0;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_error = rerr_q;

endmodule
